delay_line_ctrl: RTL

DELAY_LINE_CTRL -- requirements
Module: delay_line_ctrl

---
 rtl/delay_line_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/delay_line_ctrl.sv
// Variable-length delay line with backpressure and drain-then-apply
// delay reconfiguration.
module delay_line_ctrl #(
    parameter  int N          = 5,
    parameter  int MAX_DELAY  = 8,
    parameter  int INIT_DELAY = 4,
    localparam int DW         = $clog2(MAX_DELAY + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [N-1:0]  in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [N-1:0]  out_data,
    input  logic          out_ready,
    input  logic          cfg_valid,
    input  logic [DW-1:0] cfg_delay,
    output logic          cfg_ready,
    output logic          cfg_err,
    output logic [DW-1:0] cur_delay,
    output logic          busy
);

    localparam logic [DW-1:0] MAXD  = DW'(MAX_DELAY);
    localparam logic [DW-1:0] INITD = DW'(INIT_DELAY);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        APPLY
    } state_t;

    state_t               state;
    state_t               state_nx;
    logic [N-1:0]         s [MAX_DELAY];
    logic [MAX_DELAY-1:0] v;
    logic [MAX_DELAY-1:0] live_mask;
    logic [DW-1:0]        cur_q;
    logic [DW-1:0]        pend_q;
    logic                 err_q;
    logic                 in_flight;
    logic                 accept;

    assign cfg_ready = (state == RUN);
    assign busy      = (state != RUN);
    assign in_ready  = cfg_ready && out_ready;
    assign accept    = in_valid && in_ready;
    assign cfg_err   = err_q;
    assign cur_delay = cur_q;

    // Only stages inside the active delay window hold live words.
    always_comb begin
        live_mask = '0;
        for (int i = 0; i < MAX_DELAY; i++) begin
            live_mask[i] = (DW'(i) < cur_q);
        end
    end

    assign in_flight = |(v & live_mask);

    always_comb begin
        state_nx = state;
        unique case (state)
            RUN:     if (cfg_valid) state_nx = DRAIN;
            DRAIN:   if (!in_flight) state_nx = APPLY;
            APPLY:   state_nx = RUN;
            default: state_nx = RUN;
        endcase
    end

    // Zero delay falls through to the bypass defaults.
    always_comb begin
        out_data  = in_data;
        out_valid = in_valid && cfg_ready;
        for (int i = 0; i < MAX_DELAY; i++) begin
            if (cur_q == DW'(i + 1)) begin
                out_data  = s[i];
                out_valid = v[i] && (state != APPLY);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_DELAY; i++) begin
                s[i] <= '0;
            end
            v <= '0;
        end else begin
            if (out_ready) begin
                s[0] <= in_data;
                v[0] <= accept;
                for (int i = 1; i < MAX_DELAY; i++) begin
                    s[i] <= s[i-1];
                    v[i] <= v[i-1];
                end
            end
            if (state == APPLY) begin
                v <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= INITD;
            pend_q <= INITD;
            err_q  <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (state == RUN && cfg_valid) begin
                pend_q <= (cfg_delay > MAXD) ? MAXD : cfg_delay;
                err_q  <= (cfg_delay > MAXD);
            end
            if (state == APPLY) begin
                cur_q <= pend_q;
            end
        end
    end

endmodule
